// File: rtl/vproc_mem_pkg.sv
// vproc_mem_pkg: shared types and address helpers for the vproc memory
// latency model.
//   mem_rsp_t  - one response slot {valid, err, data}. The data field is
//                sized for the widest supported word; narrower instances
//                zero-extend into it and truncate out of it.
//   mem_idx    - word index of a byte address (low byte-lane bits dropped,
//                bits at or above the memory size masked off).
//   addr_err   - out-of-range flag: any address bit at or above the memory
//                size set.
package vproc_mem_pkg;

   localparam int MEM_W_MAX = 512;

   typedef struct packed {
      logic                 valid;
      logic                 err;
      logic [MEM_W_MAX-1:0] data;
   } mem_rsp_t;

   function automatic logic [31:0] mem_idx(input logic [31:0] addr,
                                           input int sz_log2,
                                           input int wb_log2);
      logic [31:0] mask;
      mask = (32'd1 << sz_log2) - 32'd1;
      return (addr & mask) >> wb_log2;
   endfunction

   function automatic logic addr_err(input logic [31:0] addr, input int sz_log2);
      return (addr >> sz_log2) != 32'd0;
   endfunction

endpackage

// File: rtl/vproc_mem_lat_model_if.sv
// vproc_mem_lat_model_if: req/gnt memory bus between a requester and the
// latency model.
//   req_i/addr_i/we_i/be_i/wdata_i - request, driven by the master
//   gnt_o                          - request accepted when req_i & gnt_o
//   rvalid_o/err_o/rdata_o         - one-cycle response, no backpressure
//   outstanding_o                  - accepted-but-unanswered count
interface vproc_mem_lat_model_if #(
   parameter int MEM_W           = 32,
   parameter int MAX_OUTSTANDING = 4
);
   localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);

   logic               req_i;
   logic [31:0]        addr_i;
   logic               we_i;
   logic [MEM_W/8-1:0] be_i;
   logic [MEM_W-1:0]   wdata_i;
   logic               gnt_o;
   logic               rvalid_o;
   logic               err_o;
   logic [MEM_W-1:0]   rdata_o;
   logic [OUT_W-1:0]   outstanding_o;

   modport slave (
      input  req_i, addr_i, we_i, be_i, wdata_i,
      output gnt_o, rvalid_o, err_o, rdata_o, outstanding_o
   );

   modport master (
      output req_i, addr_i, we_i, be_i, wdata_i,
      input  gnt_o, rvalid_o, err_o, rdata_o, outstanding_o
   );
endinterface

// File: rtl/vproc_mem_lat_pipe.sv
// vproc_mem_lat_pipe: LAT-stage shift register of response slots.
//   clk, rst - clock, asynchronous active-high clear of every stage
//   in_i     - slot entering stage 0 at each edge
//   out_o    - slot leaving the last stage (LAT edges after entry)
module vproc_mem_lat_pipe import vproc_mem_pkg::*; #(
   parameter int LAT = 1
) (
   input  logic     clk,
   input  logic     rst,
   input  mem_rsp_t in_i,
   output mem_rsp_t out_o
);
   mem_rsp_t [LAT-1:0] stg_q, stg_d;

   always_comb begin
      stg_d    = stg_q;
      stg_d[0] = in_i;
      for (int i = 1; i < LAT; i++) stg_d[i] = stg_q[i-1];
   end

   // Clearing every stage is what drops in-flight responses on reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) stg_q <= '0;
      else     stg_q <= stg_d;
   end

   assign out_o = stg_q[LAT-1];
endmodule

// File: rtl/vproc_mem_lat_model.sv
// vproc_mem_lat_model: word-addressed memory responder with fixed latency,
// outstanding-request cap, periodic grant stalls, error responses for
// out-of-range addresses and a backdoor word-write port.
//   clk, rst    - clock, asynchronous active-high reset (memory not reset)
//   bus         - req/gnt request and response bus (slave side)
//   bd_we_i     - backdoor full-word write, honoured even during reset
//   bd_idx_i    - backdoor word index
//   bd_wdata_i  - backdoor data
module vproc_mem_lat_model import vproc_mem_pkg::*; #(
   parameter int MEM_W           = 32,
   parameter int MEM_SZ          = 262144,
   parameter int MEM_LATENCY     = 1,
   parameter int MAX_OUTSTANDING = 4,
   parameter int STALL_PERIOD    = 0
) (
   input  logic                                  clk,
   input  logic                                  rst,
   vproc_mem_lat_model_if.slave                  bus,
   input  logic                                  bd_we_i,
   input  logic [$clog2(MEM_SZ/(MEM_W/8))-1:0]   bd_idx_i,
   input  logic [MEM_W-1:0]                      bd_wdata_i
);
   localparam int WB      = MEM_W / 8;
   localparam int WB_LOG2 = $clog2(WB);
   localparam int SZ_LOG2 = $clog2(MEM_SZ);
   localparam int DEPTH   = MEM_SZ / WB;
   localparam int IDX_W   = $clog2(DEPTH);
   localparam int OUT_W   = $clog2(MAX_OUTSTANDING + 1);

   logic [MEM_W-1:0] mem_q [DEPTH];
   logic [IDX_W-1:0] req_idx;
   logic             req_err, acc, stall;
   logic [OUT_W-1:0] outstanding_q, outstanding_d;
   mem_rsp_t         slot, rsp;

   assign req_idx = IDX_W'(mem_idx(bus.addr_i, SZ_LOG2, WB_LOG2));
   assign req_err = addr_err(bus.addr_i, SZ_LOG2);

   // A response leaving this cycle frees a slot at the same edge, so a full
   // model can still accept while rvalid is high.
   assign bus.gnt_o = ~rst & ~stall &
                      ((outstanding_q < OUT_W'(MAX_OUTSTANDING)) | rsp.valid);
   assign acc = bus.req_i & bus.gnt_o;

   generate
      if (STALL_PERIOD > 0) begin : g_stall
         localparam int SW = (STALL_PERIOD > 1) ? $clog2(STALL_PERIOD) : 1;
         logic [SW-1:0] cnt_q, cnt_d;
         always_comb cnt_d = (cnt_q == SW'(STALL_PERIOD - 1)) ? '0 : cnt_q + 1'b1;
         always_ff @(posedge clk or posedge rst) begin
            if (rst) cnt_q <= '0;
            else     cnt_q <= cnt_d;
         end
         assign stall = (cnt_q == SW'(STALL_PERIOD - 1));
      end else begin : g_nostall
         assign stall = 1'b0;
      end
   endgenerate

   // Read data is taken from the array before this edge's writes land.
   always_comb begin
      slot       = '0;
      slot.valid = acc;
      slot.err   = acc & req_err;
      if (acc & ~bus.we_i & ~req_err) slot.data = MEM_W_MAX'(mem_q[req_idx]);
   end

   always_comb begin
      outstanding_d = outstanding_q;
      if (acc & ~rsp.valid)      outstanding_d = outstanding_q + 1'b1;
      else if (~acc & rsp.valid) outstanding_d = outstanding_q - 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) outstanding_q <= '0;
      else     outstanding_q <= outstanding_d;
   end

   // Backdoor first, then enabled request bytes: the later non-blocking
   // assignment wins on overlapping bytes.
   always_ff @(posedge clk) begin
      if (bd_we_i) mem_q[bd_idx_i] <= bd_wdata_i;
      if (acc & bus.we_i & ~req_err)
         for (int i = 0; i < WB; i++)
            if (bus.be_i[i]) mem_q[req_idx][i*8 +: 8] <= bus.wdata_i[i*8 +: 8];
   end

   vproc_mem_lat_pipe #(.LAT(MEM_LATENCY)) u_pipe (
      .clk   (clk),
      .rst   (rst),
      .in_i  (slot),
      .out_o (rsp)
   );

   assign bus.rvalid_o      = rsp.valid;
   assign bus.err_o         = rsp.err;
   assign bus.rdata_o       = MEM_W'(rsp.data);
   assign bus.outstanding_o = outstanding_q;
endmodule

// File: tb/tb_vproc_mem_lat_model.sv
module tb_vproc_mem_lat_model;
   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  bd_we;
   logic [15:0] bd_idx;
   logic [31:0] bd_wdata;
   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   vproc_mem_lat_model_if #(.MEM_W(32), .MAX_OUTSTANDING(4)) ifa ();
   vproc_mem_lat_model_if #(.MEM_W(32), .MAX_OUTSTANDING(2)) ifb ();
   vproc_mem_lat_model_if #(.MEM_W(32), .MAX_OUTSTANDING(4)) ifc ();
   vproc_mem_lat_model_if #(.MEM_W(32), .MAX_OUTSTANDING(2)) ifr ();

   vproc_mem_lat_model #(.MEM_LATENCY(3), .MAX_OUTSTANDING(4), .STALL_PERIOD(0)) u_a (
      .clk(clk), .rst(rst), .bus(ifa), .bd_we_i(bd_we[0]), .bd_idx_i(bd_idx), .bd_wdata_i(bd_wdata));
   vproc_mem_lat_model #(.MEM_LATENCY(4), .MAX_OUTSTANDING(2), .STALL_PERIOD(0)) u_b (
      .clk(clk), .rst(rst), .bus(ifb), .bd_we_i(bd_we[1]), .bd_idx_i(bd_idx), .bd_wdata_i(bd_wdata));
   vproc_mem_lat_model #(.MEM_LATENCY(1), .MAX_OUTSTANDING(4), .STALL_PERIOD(3)) u_c (
      .clk(clk), .rst(rst), .bus(ifc), .bd_we_i(bd_we[2]), .bd_idx_i(bd_idx), .bd_wdata_i(bd_wdata));
   vproc_mem_lat_model #(.MEM_LATENCY(3), .MAX_OUTSTANDING(2), .STALL_PERIOD(5)) u_r (
      .clk(clk), .rst(rst), .bus(ifr), .bd_we_i(bd_we[3]), .bd_idx_i(bd_idx), .bd_wdata_i(bd_wdata));

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [3:0]  be;
      logic [31:0] wdata;
      logic        exp_err;
      logic [31:0] exp_rdata;
   } vec_t;

   typedef struct {
      int          due;
      logic        err;
      logic [31:0] data;
   } exp_rsp_t;

   vec_t        vt [11];
   int          rc_q [$];
   logic        re_q [$];
   logic [31:0] rd_q [$];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   task automatic bd_wr(input int d, input logic [15:0] idx, input logic [31:0] data);
      bd_idx = idx; bd_wdata = data; bd_we[d] = 1'b1;
      @(negedge clk);
      bd_we = '0;
   endtask

   task automatic a_drive(input logic we, input logic [31:0] addr, input logic [3:0] be,
                          input logic [31:0] wdata);
      ifa.req_i = 1'b1; ifa.we_i = we; ifa.addr_i = addr; ifa.be_i = be; ifa.wdata_i = wdata;
   endtask

   // One isolated request on A: granted at once, exactly one response 3 cycles later.
   task automatic a_single(input vec_t v, input string nm);
      int lat, nrv;
      logic e;
      logic [31:0] d;
      lat = -1; nrv = 0; e = 1'bx; d = 'x;
      a_drive(v.we, v.addr, v.be, v.wdata);
      #1 chk({nm, " gnt"}, ifa.gnt_o, 1);
      @(negedge clk);
      ifa.req_i = 1'b0; ifa.we_i = 1'b0;
      for (int k = 1; k <= 5; k++) begin
         #1;
         if (ifa.rvalid_o) begin
            nrv++;
            if (lat < 0) begin lat = k; e = ifa.err_o; d = ifa.rdata_o; end
         end
         @(negedge clk);
      end
      chk({nm, " latency"}, lat, 3);
      chk({nm, " rvalid count"}, nrv, 1);
      chk({nm, " err"}, e, v.exp_err);
      chk({nm, " rdata"}, d, v.exp_rdata);
   endtask

   task automatic a_collect(input int c0, input int n);
      rc_q.delete(); re_q.delete(); rd_q.delete();
      for (int c = c0; c < c0 + n; c++) begin
         #1;
         if (ifa.rvalid_o) begin
            rc_q.push_back(c); re_q.push_back(ifa.err_o); rd_q.push_back(ifa.rdata_o);
         end
         @(negedge clk);
      end
   endtask

   // Two requests issued in cycles 0 and 1 must answer in cycles 3 and 4.
   task automatic chk_rsp2(input string nm, input logic [31:0] d0, input logic [31:0] d1);
      chk({nm, " rsp count"}, rc_q.size(), 2);
      if (rc_q.size() == 2) begin
         chk({nm, " rsp0 cycle"}, rc_q[0], 3);
         chk({nm, " rsp0 data"}, {re_q[0], rd_q[0]}, {1'b0, d0});
         chk({nm, " rsp1 cycle"}, rc_q[1], 4);
         chk({nm, " rsp1 data"}, {re_q[1], rd_q[1]}, {1'b0, d1});
      end
   endtask

   task automatic idle_all();
      ifa.req_i = 0; ifa.addr_i = 0; ifa.we_i = 0; ifa.be_i = 0; ifa.wdata_i = 0;
      ifb.req_i = 0; ifb.addr_i = 0; ifb.we_i = 0; ifb.be_i = 0; ifb.wdata_i = 0;
      ifc.req_i = 0; ifc.addr_i = 0; ifc.we_i = 0; ifc.be_i = 0; ifc.wdata_i = 0;
      ifr.req_i = 0; ifr.addr_i = 0; ifr.we_i = 0; ifr.be_i = 0; ifr.wdata_i = 0;
   endtask

   logic [31:0] ref_mem [16];
   exp_rsp_t    mq [$];

   initial begin
      logic exp_g [8];
      int k, peak, acc_n, cyc, tm;
      logic [31:0] bq [$];
      logic [31:0] a;
      logic [3:0]  w;
      logic        rs, erv, eg, oor;
      exp_rsp_t    er;

      vt[0]  = '{0, 32'h0000_0040, 4'h0, 32'h0,         0, 32'hDEADBEEF};
      vt[1]  = '{1, 32'h0000_004C, 4'hA, 32'hAABBCCDD,  0, 32'h0};
      vt[2]  = '{0, 32'h0000_004E, 4'h0, 32'h0,         0, 32'hAA66CC88};
      vt[3]  = '{0, 32'h0004_0000, 4'h0, 32'h0,         1, 32'h0};
      vt[4]  = '{1, 32'h0004_0040, 4'hF, 32'hFFFFFFFF,  1, 32'h0};
      vt[5]  = '{0, 32'h0000_0043, 4'h0, 32'h0,         0, 32'hDEADBEEF};
      vt[6]  = '{0, 32'h8000_004C, 4'h0, 32'h0,         1, 32'h0};
      vt[7]  = '{1, 32'h0003_FFFC, 4'hF, 32'h12345678,  0, 32'h0};
      vt[8]  = '{0, 32'h0003_FFFF, 4'h0, 32'h0,         0, 32'h12345678};
      vt[9]  = '{1, 32'h0000_0040, 4'h0, 32'h0,         0, 32'h0};
      vt[10] = '{0, 32'h0000_0040, 4'h0, 32'h0,         0, 32'hDEADBEEF};
      exp_g = '{1, 1, 0, 0, 1, 1, 0, 0};

      rst = 1'b1; bd_we = '0; bd_idx = '0; bd_wdata = '0;
      idle_all();
      @(negedge clk);
      #1;
      chk("reset gnt", ifa.gnt_o, 0);
      chk("reset rvalid", ifa.rvalid_o, 0);
      chk("reset err", ifa.err_o, 0);
      chk("reset rdata", ifa.rdata_o, 0);
      chk("reset outstanding", ifa.outstanding_o, 0);

      // Preload while reset is held.
      bd_wr(0, 16'h10, 32'hDEADBEEF);
      bd_wr(0, 16'h11, 32'h11223344);
      bd_wr(0, 16'h13, 32'h55667788);
      bd_wr(0, 16'h15, 32'hCAFEF00D);
      for (int i = 0; i < 8; i++) bd_wr(1, 16'(i), 32'hB000_0000 + i);
      for (int i = 0; i < 16; i++) begin ref_mem[i] = $urandom; bd_wr(3, 16'(i), ref_mem[i]); end
      rst = 1'b0;

      for (int i = 0; i < 11; i++) a_single(vt[i], $sformatf("vec%0d", i));

      // Write then read of the same word on consecutive cycles.
      a_drive(1, 32'h44, 4'b0101, 32'hAABBCCDD); #1 chk("raw gnt0", ifa.gnt_o, 1); @(negedge clk);
      a_drive(0, 32'h44, 4'h0, 32'h0);           #1 chk("raw gnt1", ifa.gnt_o, 1); @(negedge clk);
      ifa.req_i = 0;
      a_collect(2, 4); chk_rsp2("raw", 32'h0, 32'h11BB33DD);

      // Backdoor and request write to the same word in one cycle.
      bd_idx = 16'h14; bd_wdata = 32'h01020304; bd_we[0] = 1'b1;
      a_drive(1, 32'h50, 4'b0011, 32'hFFFFEEEE); @(negedge clk);
      bd_we = '0;
      a_drive(0, 32'h50, 4'h0, 32'h0); @(negedge clk);
      ifa.req_i = 0;
      a_collect(2, 4); chk_rsp2("bd+wr", 32'h0, 32'h0102EEEE);

      // Backdoor write and read of the same word in one cycle.
      bd_idx = 16'h15; bd_wdata = 32'h0; bd_we[0] = 1'b1;
      a_drive(0, 32'h54, 4'h0, 32'h0); @(negedge clk);
      bd_we = '0; @(negedge clk);
      ifa.req_i = 0;
      a_collect(2, 4); chk_rsp2("bd+rd", 32'hCAFEF00D, 32'h0);

      // Reset with two reads in flight.
      a_drive(0, 32'h40, 4'h0, 32'h0); @(negedge clk);
      a_drive(0, 32'h44, 4'h0, 32'h0); @(negedge clk);
      #1 chk("pre-reset outstanding", ifa.outstanding_o, 2);
      ifa.req_i = 0; rst = 1'b1;
      #1;
      chk("in-reset outstanding", ifa.outstanding_o, 0);
      chk("in-reset gnt", ifa.gnt_o, 0);
      @(negedge clk);
      rst = 1'b0;
      a_collect(3, 5);
      chk("dropped rsp count", rc_q.size(), 0);
      chk("post-reset outstanding", ifa.outstanding_o, 0);
      a_single('{0, 32'h40, 4'h0, 32'h0, 0, 32'hDEADBEEF}, "post-reset rd0");
      a_single('{0, 32'h44, 4'h0, 32'h0, 0, 32'h11BB33DD}, "post-reset rd1");

      // B: latency 4, cap 2, request held for 8 cycles.
      k = 0; peak = 0;
      for (int c = 0; c < 12; c++) begin
         ifb.req_i = (c < 8); ifb.we_i = 0; ifb.addr_i = 32'(k * 4);
         #1;
         if (c < 8) chk($sformatf("cap gnt c%0d", c), ifb.gnt_o, exp_g[c]);
         if (int'(ifb.outstanding_o) > peak) peak = int'(ifb.outstanding_o);
         if (ifb.rvalid_o) bq.push_back(ifb.rdata_o);
         if (ifb.req_i && ifb.gnt_o) k++;
         @(negedge clk);
      end
      ifb.req_i = 0;
      chk("cap peak outstanding", peak, 2);
      chk("cap accepts", k, 4);
      chk("cap rsp count", bq.size(), 4);
      for (int i = 0; i < bq.size(); i++) chk($sformatf("cap rsp%0d", i), bq[i], 32'hB000_0000 + i);
      chk("cap drained", ifb.outstanding_o, 0);

      // C: stall period 3, phase pinned by a reset.
      rst = 1'b1; @(negedge clk); rst = 1'b0;
      acc_n = 0;
      for (int c = 0; c < 9; c++) begin
         ifc.req_i = 1'b1; ifc.addr_i = 32'h0;
         #1 chk($sformatf("stall gnt c%0d", c), ifc.gnt_o, (c % 3) != 2);
         if (ifc.gnt_o) acc_n++;
         @(negedge clk);
      end
      ifc.req_i = 0;
      chk("stall accepts in 9", acc_n, 6);

      // R: random traffic against a transaction-level model.
      cyc = 0; tm = 0;
      for (int n = 0; n < 500; n++) begin
         rs = (n < 2) || ($urandom_range(0, 59) == 0);
         rst = rs;
         w = 4'($urandom_range(0, 15));
         a = {26'b0, w, 2'($urandom_range(0, 3))};
         if ($urandom_range(0, 7) == 0) a = a | (32'h1 << $urandom_range(18, 31));
         ifr.req_i   = ($urandom_range(0, 2) != 0);
         ifr.we_i    = 1'($urandom_range(0, 1));
         ifr.addr_i  = a;
         ifr.be_i    = 4'($urandom_range(0, 15));
         ifr.wdata_i = $urandom;
         bd_we[3]    = ($urandom_range(0, 3) == 0);
         bd_idx      = 16'($urandom_range(0, 15));
         bd_wdata    = $urandom;
         if (rs) begin mq.delete(); cyc = 0; end
         #1;
         erv = (mq.size() > 0) && (mq[0].due == tm);
         eg  = !rs && ((cyc % 5) != 4) && ((mq.size() < 2) || erv);
         chk("rnd gnt", ifr.gnt_o, eg);
         chk("rnd rvalid", ifr.rvalid_o, erv);
         chk("rnd outstanding", ifr.outstanding_o, mq.size());
         if (erv) chk("rnd rsp", {ifr.err_o, ifr.rdata_o}, {mq[0].err, mq[0].data});
         oor = (a[31:18] != 0);
         if (!rs) begin
            if (erv) void'(mq.pop_front());
            if (ifr.req_i && eg) begin
               er.due  = tm + 3;
               er.err  = oor;
               er.data = (!ifr.we_i && !oor) ? ref_mem[w] : 32'h0;
               mq.push_back(er);
            end
         end
         if (bd_we[3]) ref_mem[bd_idx[3:0]] = bd_wdata;
         if (!rs && ifr.req_i && eg && ifr.we_i && !oor)
            for (int i = 0; i < 4; i++)
               if (ifr.be_i[i]) ref_mem[w][i*8 +: 8] = ifr.wdata_i[i*8 +: 8];
         if (!rs) begin cyc++; tm++; end
         @(negedge clk);
      end
      bd_we = '0; rst = 1'b0; idle_all();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/vproc_mem_lat_model.md
Name: vproc_mem_lat_model

Overview:
- Parametrised word-addressed memory responder for the vproc simulation environment; successor to the single-latency array model.
- Adds: a req/gnt handshake, configurable fixed latency, a cap on outstanding requests, periodic grant stalls, out-of-range error responses, write responses, and a backdoor preload port.
- Sits between vproc_top's memory port and the bench, or in parallel with the mmu as a golden model for comparison.

Parameters:
- MEM_W, 32, data word width in bits (multiple of 32).
- MEM_SZ, 262144, memory size in bytes (power of two).
- MEM_LATENCY, 1, cycles from request acceptance to response (must be >= 1).
- MAX_OUTSTANDING, 4, maximum accepted-but-unanswered requests (must be >= 1).
- STALL_PERIOD, 0, if > 0, gnt_o is forced low one cycle in every STALL_PERIOD cycles; 0 disables stalling.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-high.
- req_i  in  1  request valid.
- addr_i  in  32  byte address.
- we_i  in  1  write enable.
- be_i  in  MEM_W/8  byte enables.
- wdata_i  in  MEM_W  write data.
- gnt_o  out  1  request accepted this cycle when req_i & gnt_o.
- rvalid_o  out  1  response valid.
- err_o  out  1  response error, qualified by rvalid_o.
- rdata_o  out  MEM_W  read data, qualified by rvalid_o.
- outstanding_o  out  $clog2(MAX_OUTSTANDING+1)  in-flight request count.
- bd_we_i  in  1  backdoor word write.
- bd_idx_i  in  $clog2(MEM_SZ/(MEM_W/8))  backdoor word index.
- bd_wdata_i  in  MEM_W  backdoor data.

Behaviour:
- Reset state: gnt_o=0, rvalid_o=0, err_o=0, rdata_o=0, outstanding_o=0, latency pipeline cleared, stall counter=0. Memory contents are NOT reset.
- Reset mid-operation: all in-flight responses are dropped; no rvalid_o is ever produced for them.
- Word index = addr_i[$clog2(MEM_SZ)-1 : $clog2(MEM_W/8)]. Low address bits are ignored.
- Error condition: addr_i[31:$clog2(MEM_SZ)] != 0 raises error.
  - An erroring write does not modify memory.
  - An erroring read returns rdata 0.
- gnt_o = ~rst & ~stall & ((outstanding < MAX_OUTSTANDING) | rvalid_o). It is combinational and independent of req_i.
- Stall counter:
  - Free-running 0..STALL_PERIOD-1, wrapping.
  - stall = (STALL_PERIOD > 0) & (counter == STALL_PERIOD-1).
  - The counter runs regardless of traffic.
- Acceptance at a clock edge where req_i & gnt_o:
  - Write: each byte i with be_i[i] set is written at that edge.
  - Read: data is sampled from the array at that edge, before any same-edge write takes effect.
  - A slot {valid=1, err, data} enters the latency pipeline. For writes, data is 0.
- Latency pipeline:
  - A MEM_LATENCY-deep shift register of {valid, err, data}.
  - The response appears on rvalid_o/err_o/rdata_o exactly MEM_LATENCY cycles after the acceptance edge and is held for one cycle only.
  - No response backpressure.
  - At most one acceptance per cycle, so responses never collide. Back-to-back accepts give back-to-back responses in order.
- outstanding_o:
  - +1 on acceptance, -1 when rvalid_o is high.
  - Both in the same cycle leaves it unchanged.
  - Never exceeds MAX_OUTSTANDING.
- Throughput: if MAX_OUTSTANDING < MEM_LATENCY, throughput is limited to MAX_OUTSTANDING accepts per MEM_LATENCY cycles.
- Backdoor write:
  - Writes a full word at the clock edge, even during reset.
  - If it targets the same word as an accepted write in the same cycle, the backdoor write is applied first and enabled request bytes override it.
  - A read accepted in the same cycle sees the pre-backdoor contents.
- Read-after-write: a read accepted one cycle after a write to the same word returns the written data.

Decomposition:
- Shared package vproc_mem_pkg holds:
  - typedef mem_rsp_t {valid, err, data}.
  - function mem_idx(addr), returning the word index.
  - function addr_err(addr), returning the out-of-range flag.
- One natural sub-module, vproc_mem_lat_pipe: a parametrised MEM_LATENCY-stage shift register of mem_rsp_t with asynchronous clear.
- The array, grant logic, stall counter and outstanding counter stay in the top module.

Test Plan:
- Preload word 0x10 via the backdoor with 0xDEADBEEF (MEM_LATENCY=3), then read addr 0x40 → gnt_o=1, rvalid_o exactly 3 cycles later, rdata_o=0xDEADBEEF, err_o=0.
- Write addr 0x44, be=4'b0101, wdata=0xAABBCCDD over existing 0x11223344, then read the next cycle → rdata 0x11BB33DD, write response rvalid with rdata 0.
- MEM_LATENCY=4, MAX_OUTSTANDING=2, req_i held high for 8 cycles → gnt_o pattern 1,1,0,0 repeating, outstanding_o peaks at 2, responses in order.
- STALL_PERIOD=3 with continuous req_i → gnt_o low every third cycle; 6 accepts in 9 cycles.
- Read addr 0x0004_0000 (MEM_SZ=262144) → err_o=1, rdata_o=0. Write to the same address leaves memory unchanged.
- Assert rst with 2 requests in flight → rvalid_o never asserts for them, outstanding_o=0. After release, a new read responds after MEM_LATENCY cycles and memory contents are intact.
